bus_arbiter_rr4: RTL and testbench

//   Round-robin arbiter sharing one 64-bit datapath between four requesters.

---
 rtl/bus_arbiter_rr4_if.sv | 29 ++
 rtl/bus_arbiter_rr4.sv | 114 +++++++++++
 tb/tb_bus_arbiter_rr4.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_rr4_if.sv
// Handshake bundle between the four producers, the round-robin arbiter and
// the shared downstream sink.
interface bus_arbiter_rr4_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        req_valid;
  logic [3:0]        req_last;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic [DATA_W-1:0] req_data2;
  logic [DATA_W-1:0] req_data3;
  logic [3:0]        req_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  // Arbiter side
  modport slave (
    input  req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
    output req_ready, out_valid, out_data, out_last
  );

  // Producer/sink side
  modport master (
    output req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bus_arbiter_rr4.sv
// Round-robin arbiter sharing one datapath between four requesters.
// A grant is locked for a whole burst; the arbiter returns to IDLE after the
// last beat or after TIMEOUT consecutive cycles with no valid from the owner.
module bus_arbiter_rr4 #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  bus_arbiter_rr4_if.slave    bus,
  output logic [1:0]          grant_sel,
  output logic                busy,
  output logic                timeout_pulse
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_grant, last_nxt, sel_nxt;
  logic [1:0]  pick, cand;
  logic        pick_vld;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic        sel_valid, out_valid_i, xfer;

  // Round-robin search starting just after the previous grant
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_grant + i[1:0];
      if (!pick_vld && bus.req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Datapath mux driven by the registered select
  always_comb begin
    case (grant_sel)
      2'd0:    bus.out_data = bus.req_data0;
      2'd1:    bus.out_data = bus.req_data1;
      2'd2:    bus.out_data = bus.req_data2;
      default: bus.out_data = bus.req_data3;
    endcase
  end

  // Handshake steering toward the granted requester only
  always_comb begin
    sel_valid   = bus.req_valid[grant_sel];
    out_valid_i = (state == BURST) && sel_valid;
    bus.out_valid = out_valid_i;
    bus.out_last  = bus.req_last[grant_sel];
    bus.req_ready = '0;
    if (state == BURST) bus.req_ready[grant_sel] = bus.out_ready;
    xfer = out_valid_i && bus.out_ready;
    busy = (state == BURST);
  end

  // Next-state, grant and idle-counter logic
  always_comb begin
    state_nxt     = state;
    sel_nxt       = grant_sel;
    last_nxt      = last_grant;
    cnt_nxt       = cnt;
    timeout_pulse = 1'b0;
    cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pick_vld) begin
          sel_nxt   = pick;
          last_nxt  = pick;
          state_nxt = BURST;
        end
      end
      default: begin
        if (xfer) begin
          // A transfer always clears the counter, so a last beat can never
          // coincide with a timeout.
          cnt_nxt = '0;
          if (bus.out_last) state_nxt = IDLE;
        end else if (!sel_valid) begin
          cnt_nxt = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == CNT_MAX)) begin
            timeout_pulse = 1'b1;
            state_nxt     = IDLE;
            cnt_nxt       = '0;
          end
        end
      end
    endcase
  end

  // State registers; last_grant resets to 3 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_sel  <= '0;
      last_grant <= 2'd3;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant_sel  <= sel_nxt;
      last_grant <= last_nxt;
      cnt        <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Directed bench for the four-way round-robin burst arbiter.
module tb_bus_arbiter_rr4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant_sel;
  logic       busy;
  logic       timeout_pulse;

  bus_arbiter_rr4_if #(.DATA_W(64)) bus ();

  bus_arbiter_rr4 #(.DATA_W(64), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .grant_sel     (grant_sel),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic        ordy;
    logic [3:0]  rdy;
    logic        v;
    logic [1:0]  sel;
    logic        b;
    logic        chk_data;
    logic [63:0] data;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rv, input logic [3:0] rl, input logic ordy);
    bus.req_valid = rv;
    bus.req_last  = rl;
    bus.out_ready = ordy;
  endtask

  initial begin
    // round robin over four always-valid single-beat requesters
    vt[0]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 64'h0};
    vt[1]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 64'hA0};
    vt[2]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 64'h0};
    vt[3]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 64'hA1};
    vt[4]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 64'h0};
    vt[5]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 64'hA2};
    vt[6]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 64'h0};
    vt[7]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b1, 64'hA3};
    vt[8]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0, 64'h0};
    vt[9]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 64'hA0};
    // lone requester 1, regranted every two cycles
    vt[10] = '{4'h2, 4'h2, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 64'h0};
    vt[11] = '{4'h2, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 64'hA1};
    vt[12] = '{4'h2, 4'h2, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 64'h0};
    vt[13] = '{4'h2, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 64'hA1};
    vt[14] = '{4'h2, 4'h2, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 64'h0};
    vt[15] = '{4'h2, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 64'hA1};
    // nobody requesting: no spurious grants
    vt[16] = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 64'h0};
    vt[17] = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 64'h0};

    rst_n = 1'b0;
    drive(4'h0, 4'h0, 1'b0);
    bus.req_data0 = 64'hA0;
    bus.req_data1 = 64'hA1;
    bus.req_data2 = 64'hA2;
    bus.req_data3 = 64'hA3;
    cyc();
    cyc();
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_sel",   64'(grant_sel), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_pulse", 64'(timeout_pulse), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].rv, vt[i].rl, vt[i].ordy);
      #2;
      check($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(vt[i].rdy));
      check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vt[i].v));
      check($sformatf("v%0d_sel", i),   64'(grant_sel), 64'(vt[i].sel));
      check($sformatf("v%0d_busy", i),  64'(busy), 64'(vt[i].b));
      check($sformatf("v%0d_pulse", i), 64'(timeout_pulse), 64'd0);
      if (vt[i].chk_data) check($sformatf("v%0d_data", i), bus.out_data, vt[i].data);
      cyc();
    end

    // reset in the middle of a requester-2 burst
    drive(4'b0100, 4'b0000, 1'b1);
    #2;
    check("t5_idle_busy", 64'(busy), 64'd0);
    cyc();
    #2;
    check("t5_burst_sel",  64'(grant_sel), 64'd2);
    check("t5_burst_busy", 64'(busy), 64'd1);
    check("t5_burst_data", bus.out_data, 64'hA2);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t5_rst_ready", 64'(bus.req_ready), 64'd0);
    check("t5_rst_busy",  64'(busy), 64'd0);
    check("t5_rst_sel",   64'(grant_sel), 64'd0);
    cyc();
    rst_n = 1'b1;
    bus.req_data0 = 64'h1;
    drive(4'b0101, 4'b0100, 1'b1);
    #2;
    check("t5_rel_busy", 64'(busy), 64'd0);
    cyc();

    // four-beat burst on requester 0 while requester 2 waits
    for (int b = 1; b <= 4; b++) begin
      bus.req_data0 = 64'(b);
      bus.req_last  = (b == 4) ? 4'b0101 : 4'b0100;
      #2;
      check($sformatf("t2_b%0d_valid", b), 64'(bus.out_valid), 64'd1);
      check($sformatf("t2_b%0d_data", b),  bus.out_data, 64'(b));
      check($sformatf("t2_b%0d_sel", b),   64'(grant_sel), 64'd0);
      check($sformatf("t2_b%0d_ready", b), 64'(bus.req_ready), 64'b0001);
      check($sformatf("t2_b%0d_last", b),  64'(bus.out_last), 64'(b == 4));
      cyc();
    end
    bus.req_valid = 4'b0100;
    #2;
    check("t2_gap_busy",  64'(busy), 64'd0);
    check("t2_gap_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    #2;
    check("t2_r2_sel",   64'(grant_sel), 64'd2);
    check("t2_r2_busy",  64'(busy), 64'd1);
    check("t2_r2_data",  bus.out_data, 64'hA2);
    check("t2_r2_ready", 64'(bus.req_ready), 64'b0100);
    cyc();

    // requester 1 burst stalled by the sink for three cycles
    bus.req_data1 = 64'h11;
    drive(4'b0010, 4'b0000, 1'b1);
    #2;
    check("t3_idle_busy", 64'(busy), 64'd0);
    cyc();
    #2;
    check("t3_b1_data",  bus.out_data, 64'h11);
    check("t3_b1_ready", 64'(bus.req_ready), 64'b0010);
    cyc();
    bus.req_data1 = 64'h12;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("t3_st%0d_valid", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("t3_st%0d_data", k),  bus.out_data, 64'h12);
      check($sformatf("t3_st%0d_ready", k), 64'(bus.req_ready), 64'd0);
      check($sformatf("t3_st%0d_pulse", k), 64'(timeout_pulse), 64'd0);
      check($sformatf("t3_st%0d_busy", k),  64'(busy), 64'd1);
      cyc();
    end
    drive(4'b0010, 4'b0010, 1'b1);
    #2;
    check("t3_res_ready", 64'(bus.req_ready), 64'b0010);
    check("t3_res_data",  bus.out_data, 64'h12);
    cyc();
    bus.req_valid = 4'b0000;
    #2;
    check("t3_end_busy", 64'(busy), 64'd0);
    cyc();

    // requester 3 goes quiet after one beat: forced release after 8 cycles
    drive(4'b1000, 4'b0000, 1'b1);
    #2;
    check("t4_idle_busy", 64'(busy), 64'd0);
    cyc();
    #2;
    check("t4_beat_ready", 64'(bus.req_ready), 64'b1000);
    check("t4_beat_sel",   64'(grant_sel), 64'd3);
    cyc();
    bus.req_valid = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      #2;
      check($sformatf("t4_w%0d_pulse", k), 64'(timeout_pulse), 64'(k == 8));
      check($sformatf("t4_w%0d_busy", k),  64'(busy), 64'd1);
      if (k == 8) bus.req_valid = 4'b0101;
      cyc();
    end
    #2;
    check("t4_rel_busy",  64'(busy), 64'd0);
    check("t4_rel_pulse", 64'(timeout_pulse), 64'd0);
    cyc();
    #2;
    check("t4_next_sel",  64'(grant_sel), 64'd0);
    check("t4_next_busy", 64'(busy), 64'd1);
    bus.req_valid = 4'b0000;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
